sw_button_ctrl: RTL and testbench
=================================

SW_BUTTON_CTRL -- requirements
Module: sw_button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, SHALL set the debounce counter width; it SHALL be at least clog2(DEBOUNCE_CYCLES).
REQ-003 clk  in  1  single design clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 btn_start_raw  in  1  asynchronous start/stop button, high = pressed.
REQ-006 btn_lap_raw  in  1  asynchronous lap/clear button, high = pressed.
REQ-007 run  out  1  stopwatch counter enable (level).
REQ-008 freeze  out  1  display holds the lap snapshot while high; the counter keeps running.
REQ-009 clear  out  1  one-cycle pulse that zeroes the stopwatch counter.
REQ-010 state  out  2  current FSM state, for debug and verification.

Function
REQ-011 Each raw button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Debounce rule:
- while the synchronized level differs from the debounced level, the counter increments each cycle;
- when the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level takes the synchronized value and the counter returns to 0;
- whenever the levels match, the counter returns to 0.
REQ-013 A press event SHALL be a registered one-cycle pulse on a 0->1 transition of the debounced level; a release SHALL produce no event.
REQ-014 Latency SHALL be exact: with raw held high from before edge k, the press pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2, and the FSM state changes at edge k+DEBOUNCE_CYCLES+3.
REQ-015 A raw glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no event.
REQ-016 A held button SHALL produce exactly one event, with no auto-repeat.
REQ-017 FSM states SHALL be IDLE=2'b00, RUNNING=2'b01, STOPPED=2'b10, LAP=2'b11.
REQ-018 Transitions:
- IDLE: start -> RUNNING; lap ignored.
- RUNNING: start -> STOPPED; lap -> LAP.
- LAP: lap -> RUNNING; start -> STOPPED.
- STOPPED: start -> RUNNING; lap -> IDLE.
REQ-019 If start and lap events occur in the same cycle, the start event SHALL win and the lap event SHALL be discarded, not queued.
REQ-020 Outputs are registered functions of state:
- run=1 in RUNNING and LAP;
- freeze=1 in LAP only;
- run=0 and freeze=0 otherwise.
REQ-021 clear SHALL be high for exactly one cycle, the cycle in which state first reads IDLE after a STOPPED->IDLE transition, and low otherwise except during reset (REQ-023).
REQ-022 LAP->STOPPED SHALL drop freeze and run on the same edge, so the display shows the live (stopped) count.

Reset
REQ-023 While rst is high at a clock edge:
- state=IDLE, run=0, freeze=0, clear=1;
- synchronizers, debounced levels, counters and event registers are 0.
REQ-024 On the first edge after rst deasserts, clear SHALL drop to 0.
REQ-025 A button held through reset SHALL generate one press event DEBOUNCE_CYCLES+3 edges after reset release, counting the hold from that release.
REQ-026 Reset mid-debounce or mid-LAP SHALL discard all pending progress, with no residual events.

Structure
REQ-027 Package sw_pkg SHALL hold the state encoding constants (IDLE, RUNNING, STOPPED, LAP) and the default DEBOUNCE_CYCLES; the stopwatch top and display logic SHALL import the same package.
REQ-028 Sub-module sw_debounce (synchronizer, counter, event pulse; ports clk, rst, raw_in, level_out, press_out) SHALL be instantiated twice; the FSM SHALL live in sw_button_ctrl.
REQ-029 The implementation SHALL be at most 250 lines of RTL, with no latches and no gated or derived clocks.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset with no presses -> clear=1 during rst and 0 afterwards; state=00, run=0, freeze=0 held for 50 cycles.
REQ-031 Raw start high from edge 10, held 20 cycles -> state=01 and run=1 at edge 17; exactly one event; release causes no change.
REQ-032 Sequence start, lap, lap, start, lap (each 10 cycles high, 10 low) -> states 01,11,01,10,00; freeze high only in 11; clear pulses exactly once, on entry to 00.
REQ-033 Raw start 3-cycle glitches repeated 10 times -> state remains 00; no press pulse.
REQ-034 Start and lap rising on the same edge while in RUNNING -> STOPPED (10), not LAP; lap event dropped.
REQ-035 rst asserted for 1 cycle while in LAP with lap held -> state=00, freeze=0; one lap event after release is ignored in IDLE.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared stopwatch definitions: FSM state encoding,
// default debounce length and the button-event transition rule.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    STOPPED = 2'b10,
    LAP     = 2'b11
  } sw_state_t;

  localparam int DEBOUNCE_DEFAULT = 16;

  // Start takes priority over lap; a simultaneous lap is dropped.
  function automatic sw_state_t next_state(
    input sw_state_t s,
    input logic      start,
    input logic      lap
  );
    next_state = s;
    unique case (s)
      IDLE: begin
        if (start) next_state = RUNNING;
      end
      RUNNING: begin
        if (start)    next_state = STOPPED;
        else if (lap) next_state = LAP;
      end
      LAP: begin
        if (start)    next_state = STOPPED;
        else if (lap) next_state = RUNNING;
      end
      STOPPED: begin
        if (start)    next_state = RUNNING;
        else if (lap) next_state = IDLE;
      end
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Button conditioner: 2-flop sync, stability counter, press pulse.
// Ports: clk, rst (sync, high), raw_in, level_out, press_out.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic press_out
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      level_out <= 1'b0;
      level_d   <= 1'b0;
      press_out <= 1'b0;
      cnt       <= '0;
    end else begin
      meta      <= raw_in;
      sync      <= meta;
      level_d   <= level_out;
      // rising edge of the accepted level only
      press_out <= level_out & ~level_d;
      if (sync == level_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_out <= sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_button_ctrl.sv
// Stopwatch control: two debounced buttons drive a 4-state FSM.
// Ports: clk, rst, btn_start_raw, btn_lap_raw -> run, freeze, clear, state.
module sw_button_ctrl
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_raw,
  input  logic       btn_lap_raw,
  output logic       run,
  output logic       freeze,
  output logic       clear,
  output logic [1:0] state
);

  logic      start_ev;
  logic      lap_ev;
  logic      unused_start_lvl;
  logic      unused_lap_lvl;
  sw_state_t st;
  sw_state_t nxt;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_start (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (btn_start_raw),
    .level_out(unused_start_lvl),
    .press_out(start_ev)
  );

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lap (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (btn_lap_raw),
    .level_out(unused_lap_lvl),
    .press_out(lap_ev)
  );

  assign nxt   = next_state(st, start_ev, lap_ev);
  assign state = st;

  // Outputs follow the next state so they change on
  // the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      run    <= 1'b0;
      freeze <= 1'b0;
      clear  <= 1'b1;
    end else begin
      st     <= nxt;
      run    <= (nxt == RUNNING) || (nxt == LAP);
      freeze <= (nxt == LAP);
      clear  <= (st == STOPPED) && (nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_sw_button_ctrl.sv
// Self-checking bench for sw_button_ctrl with DEBOUNCE_CYCLES=4.
// Window-based reference model plus directed literal checks.
module tb_sw_button_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bs  = 1'b0;
  logic       bl  = 1'b0;
  logic       run;
  logic       freeze;
  logic       clear;
  logic [1:0] state;

  sw_button_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start_raw(bs),
    .btn_lap_raw  (bl),
    .run          (run),
    .freeze       (freeze),
    .clear        (clear),
    .state        (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int clears = 0;

  task automatic check(input string name,
                       input logic [1:0] act,
                       input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0b, expected %0b",
               name, $time, act, exp);
    end
  endtask

  // Reference model: raw history per button; the accepted level
  // flips once the last N synchronized samples all disagree with it.
  bit         hist [2][N+2];
  bit         lvl  [2];
  bit         lvl_p[2];
  bit         prs  [2];
  logic [1:0] tbl  [4][3];
  logic [1:0] m_state;
  bit         m_clear;
  bit         m_valid = 0;
  bit         last_rst = 1;

  initial begin
    tbl[0] = '{2'd0, 2'd1, 2'd0};
    tbl[1] = '{2'd1, 2'd2, 2'd3};
    tbl[2] = '{2'd2, 2'd1, 2'd0};
    tbl[3] = '{2'd3, 2'd2, 2'd1};
  end

  always @(posedge clk) begin
    bit all_diff;
    int ev;
    logic [1:0] ns;
    last_rst = rst;
    for (int b = 0; b < 2; b++) begin
      for (int i = N + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = (b == 0) ? bs : bl;
    end
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N + 2; i++) hist[b][i] = 0;
        lvl[b] = 0; lvl_p[b] = 0; prs[b] = 0;
      end
      m_state = 2'd0;
      m_clear = 1;
    end else begin
      ev = prs[0] ? 1 : (prs[1] ? 2 : 0);
      ns = tbl[m_state][ev];
      m_clear = (m_state == 2'd2) && (ns == 2'd0);
      m_state = ns;
      for (int b = 0; b < 2; b++) begin
        prs[b] = lvl[b] & ~lvl_p[b];
        lvl_p[b] = lvl[b];
        all_diff = 1;
        for (int i = 2; i < N + 2; i++)
          if (hist[b][i] == lvl[b]) all_diff = 0;
        if (all_diff) lvl[b] = ~lvl[b];
      end
    end
    m_valid = 1;
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("state", state, m_state);
      check("run", {1'b0, run},
            {1'b0, (m_state == 2'd1) || (m_state == 2'd3)});
      check("freeze", {1'b0, freeze}, {1'b0, m_state == 2'd3});
      check("clear", {1'b0, clear}, {1'b0, m_clear});
      if (clear && !last_rst) clears++;
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit l);
    @(negedge clk);
    bs = s; bl = l;
    negs(10);
    bs = 0; bl = 0;
    negs(10);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1;
    negs(n);
    rst = 0;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #2;
    check("rst_clear", {1'b0, clear}, 2'd1);
    check("rst_state", state, 2'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #2;
    check("clear_drop", {1'b0, clear}, 2'd0);
    negs(50);
    check("idle_state", state, 2'd0);
    check("idle_run", {1'b0, run}, 2'd0);

    // short glitches never reach the FSM
    for (int g = 0; g < 10; g++) begin
      @(negedge clk); bs = 1;
      negs(3); bs = 0;
      negs(6);
    end
    negs(10);
    check("glitch_state", state, 2'd0);

    // exact latency: edge k+N+3 after raw rises before edge k
    @(negedge clk); bs = 1;
    repeat (7) @(posedge clk);
    #2;
    check("lat_before", state, 2'd0);
    @(posedge clk); #2;
    check("lat_state", state, 2'd1);
    check("lat_run", {1'b0, run}, 2'd1);
    repeat (12) @(posedge clk);
    @(negedge clk); bs = 0;
    negs(20);
    check("release_state", state, 2'd1);

    // full sequence from IDLE
    do_reset(2);
    negs(5);
    check("clears_before", clears[1:0], 2'd0);
    press(1, 0); check("seq1", state, 2'd1);
    press(0, 1); check("seq2", state, 2'd3);
    check("seq2_frz", {1'b0, freeze}, 2'd1);
    press(0, 1); check("seq3", state, 2'd1);
    press(1, 0); check("seq4", state, 2'd2);
    press(0, 1); check("seq5", state, 2'd0);
    check("clears_after", clears[1:0], 2'd1);

    // simultaneous start and lap in RUNNING
    press(1, 0); check("sim_pre", state, 2'd1);
    press(1, 1); check("sim_state", state, 2'd2);
    check("sim_frz", {1'b0, freeze}, 2'd0);
    check("sim_run", {1'b0, run}, 2'd0);

    // reset while in LAP with lap still held
    press(1, 0);
    @(negedge clk); bl = 1;
    negs(10);
    check("lap_pre", state, 2'd3);
    rst = 1;
    @(negedge clk); rst = 0;
    check("lap_rst_state", state, 2'd0);
    check("lap_rst_frz", {1'b0, freeze}, 2'd0);
    negs(15);
    check("lap_held_idle", state, 2'd0);
    bl = 0;
    negs(10);
    check("lap_end_idle", state, 2'd0);
    check("clears_end", clears[1:0], 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
